// File: rtl/seq_divider.sv
// Multicycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results hold from the edge entering DONE until the next operation completes.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  // StZero spends the single cycle between acceptance and DONE for a zero divisor.
  typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] rs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dq_step;
  logic [WIDTH-1:0] rem_step;
  logic             accept;

  always_comb begin
    rs    = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
    trial = {1'b0, rs} - {1'b0, dv_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      dq_step  = {dq_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = rs;
      dq_step  = {dq_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    dv_d    = dv_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rout_d  = rout_q;
    dz_d    = dz_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: accept = start;
      StRun: begin
        busy  = 1'b1;
        dq_d  = dq_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          quo_d   = dq_step;
          rout_d  = rem_step;
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      StZero: begin
        quo_d   = '1;
        rout_d  = dq_q;
        dz_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        accept  = start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      dq_d    = dividend;
      dv_d    = divisor;
      rem_d   = '0;
      cnt_d   = '0;
      state_d = (divisor == '0) ? StZero : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dq_q    <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rout_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rout_q  <= rout_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rout_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, corner sequences and random
// operands compared against plain arithmetic.
module tb_seq_divider;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request in the current (negedge) slot; scramble operands after acceptance.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    accept(a, b);
  endtask

  // Returns edges from the accepting edge to the done cycle, and busy cycles seen.
  // Leaves the caller at the negedge inside the done cycle.
  task automatic wait_done(output int lat, output int bc);
    bit overlap;
    lat = 0;
    bc = 0;
    overlap = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done) break;
      if (busy) bc++;
      @(posedge clk);
      lat++;
      if (lat > 200) begin
        chk("done_timeout", 64'(lat), 64'd0);
        break;
      end
    end
    chk("busy_done_overlap", 64'(overlap), 64'd0);
  endtask

  task automatic check_model(input string tag, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input int lat, input int bc);
    logic [WIDTH-1:0] eq, er;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
    chk({tag, "_remainder"}, 64'(remainder), 64'(er));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(b == 0));
    chk({tag, "_latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'(WIDTH));
    chk({tag, "_busy_cycles"}, 64'(bc), (b == 0) ? 64'd0 : 64'(WIDTH));
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat, bc, n;
    logic [WIDTH-1:0] a, b;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    vecs[4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
    vecs[5] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vecs[7] = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_dz", 64'(div_by_zero), 64'd0);

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      chk($sformatf("vec%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), 64'(div_by_zero), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].b == 0 ? 64'd1 : 64'(WIDTH));
      chk($sformatf("vec%0d_busy", i), 64'(bc), vecs[i].b == 0 ? 64'd0 : 64'(WIDTH));
    end

    // Results hold through idle.
    repeat (5) @(negedge clk);
    chk("hold_quotient", 64'(quotient), 64'd1);
    chk("hold_done_low", 64'(done), 64'd0);

    // Start ignored mid-run; operands already scrambled after acceptance.
    launch(32'd1000, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    accept(32'd50, 32'd5);
    wait_done(lat, bc);
    chk("ignore_latency", 64'(lat + 10), 64'(WIDTH));
    chk("ignore_quotient", 64'(quotient), 64'd111);
    chk("ignore_remainder", 64'(remainder), 64'd1);
    count_dones(40, n);
    chk("ignore_single_done", 64'(n), 64'd0);

    // Reset aborts a run: outputs clear and no done follows.
    launch(32'd1000, 32'd9);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dz", 64'(div_by_zero), 64'd0);
    count_dones(40, n);
    chk("abort_no_done", 64'(n), 64'd0);
    launch(32'd77, 32'd7);
    wait_done(lat, bc);
    check_model("after_abort", 32'd77, 32'd7, lat, bc);

    // Back-to-back: new request accepted in the done cycle.
    launch(32'd100, 32'd7);
    wait_done(lat, bc);
    check_model("b2b_first", 32'd100, 32'd7, lat, bc);
    accept(32'd200, 32'd3);
    wait_done(lat, bc);
    check_model("b2b_second", 32'd200, 32'd3, lat, bc);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = WIDTH'($urandom_range(1, 255));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      launch(a, b);
      wait_done(lat, bc);
      check_model($sformatf("rand%0d", i), a, b, lat, bc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
